// File: rtl/unsigned_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : unsigned_product_accumulator
// Brief    : Sums fixed-length bursts of unsigned products into a wide
//            accumulator and hands each total downstream over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module unsigned_product_accumulator #(
  parameter int PRODUCT_WIDTH = 64,
  parameter int ACC_WIDTH     = 72,
  parameter int BURST_LEN     = 16,
  localparam int COUNT_WIDTH  = $clog2(BURST_LEN) + 1
) (
  input  logic                     Clk_In,
  input  logic                     Reset_In,
  input  logic                     Clear_In,
  input  logic [PRODUCT_WIDTH-1:0] Product_In,
  input  logic                     Product_Valid_In,
  output logic                     Product_Ready_Out,
  output logic [ACC_WIDTH-1:0]     Accumulated_Result_Out,
  output logic                     Result_Valid_Out,
  input  logic                     Result_Ready_In,
  output logic                     Overflow_Out,
  output logic [COUNT_WIDTH-1:0]   Count_Out
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] c_last_count = COUNT_WIDTH'(BURST_LEN - 1);
  localparam logic [COUNT_WIDTH-1:0] c_count_one  = COUNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic [ACC_WIDTH:0]     w_sum;
  logic                   w_take;

  // Ready depends only on state and reset, never on the upstream valid.
  assign Product_Ready_Out = (state_q == ST_ACCUM) && !Reset_In;
  assign w_take            = Product_Valid_In && Product_Ready_Out;
  assign w_sum             = {1'b0, acc_q} + (ACC_WIDTH + 1)'(Product_In);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (Clear_In) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (state_q == ST_HOLD) begin
      if (Result_Ready_In) begin
        state_d = ST_ACCUM;
        acc_d   = '0;
        count_d = '0;
        ovf_d   = 1'b0;
      end
    end else if (w_take) begin
      acc_d   = w_sum[ACC_WIDTH-1:0];
      ovf_d   = ovf_q | w_sum[ACC_WIDTH];
      count_d = count_q + c_count_one;
      if (count_q == c_last_count) begin
        state_d = ST_HOLD;
      end
    end
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Accumulated_Result_Out = acc_q;
  assign Result_Valid_Out       = (state_q == ST_HOLD);
  assign Overflow_Out           = ovf_q;
  assign Count_Out              = count_q;

endmodule
`default_nettype wire

// File: tb/tb_unsigned_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_unsigned_product_accumulator
// Brief    : Self-checking bench: vector table, corner sequences, random run
//            against a burst-list reference model on four configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unsigned_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        pv  = 1'b0;
  logic        rr  = 1'b0;
  logic [63:0] pin = '0;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // a: BURST_LEN=4, b: defaults, c: ACC_WIDTH=64/BURST_LEN=2, d: BURST_LEN=1
  logic a_rdy, a_vld, a_ovf;  logic [71:0] a_acc;  logic [2:0] a_cnt;
  logic b_rdy, b_vld, b_ovf;  logic [71:0] b_acc;  logic [4:0] b_cnt;
  logic c_rdy, c_vld, c_ovf;  logic [63:0] c_acc;  logic [1:0] c_cnt;
  logic d_rdy, d_vld, d_ovf;  logic [71:0] d_acc;  logic [0:0] d_cnt;

  unsigned_product_accumulator #(.BURST_LEN(4)) u_dut_a (
    .Clk_In(clk), .Reset_In(rst), .Clear_In(clr), .Product_In(pin),
    .Product_Valid_In(pv), .Product_Ready_Out(a_rdy), .Accumulated_Result_Out(a_acc),
    .Result_Valid_Out(a_vld), .Result_Ready_In(rr), .Overflow_Out(a_ovf), .Count_Out(a_cnt));

  unsigned_product_accumulator u_dut_b (
    .Clk_In(clk), .Reset_In(rst), .Clear_In(clr), .Product_In(pin),
    .Product_Valid_In(pv), .Product_Ready_Out(b_rdy), .Accumulated_Result_Out(b_acc),
    .Result_Valid_Out(b_vld), .Result_Ready_In(rr), .Overflow_Out(b_ovf), .Count_Out(b_cnt));

  unsigned_product_accumulator #(.ACC_WIDTH(64), .BURST_LEN(2)) u_dut_c (
    .Clk_In(clk), .Reset_In(rst), .Clear_In(clr), .Product_In(pin),
    .Product_Valid_In(pv), .Product_Ready_Out(c_rdy), .Accumulated_Result_Out(c_acc),
    .Result_Valid_Out(c_vld), .Result_Ready_In(rr), .Overflow_Out(c_ovf), .Count_Out(c_cnt));

  unsigned_product_accumulator #(.BURST_LEN(1)) u_dut_d (
    .Clk_In(clk), .Reset_In(rst), .Clear_In(clr), .Product_In(pin),
    .Product_Valid_In(pv), .Product_Ready_Out(d_rdy), .Accumulated_Result_Out(d_acc),
    .Result_Valid_Out(d_vld), .Result_Ready_In(rr), .Overflow_Out(d_ovf), .Count_Out(d_cnt));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual %0h required %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; pv = 1'b0; rr = 1'b0; pin = '0;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [63:0] p;
    logic        c;
    logic        r;
    logic [71:0] e_acc;
    int          e_cnt;
    logic        e_vld;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_row(logic v, logic [63:0] p, logic c, logic r,
                                  logic [71:0] e_acc, int e_cnt, logic e_vld);
    vec_t t;
    t.v = v; t.p = p; t.c = c; t.r = r;
    t.e_acc = e_acc; t.e_cnt = e_cnt; t.e_vld = e_vld;
    vecs.push_back(t);
  endfunction

  // Reference model: list of accepted products in the open burst plus a hold flag.
  logic [63:0] mq[4][$];
  logic        mhold[4];

  function automatic void model_clear(int m);
    mq[m].delete();
    mhold[m] = 1'b0;
  endfunction

  function automatic void model_step(int m, int burst, logic c, logic v, logic [63:0] p, logic r);
    if (c) model_clear(m);
    else if (mhold[m]) begin
      if (r) model_clear(m);
    end else if (v) begin
      mq[m].push_back(p);
      if (mq[m].size() == burst) mhold[m] = 1'b1;
    end
  endfunction

  function automatic logic [127:0] model_sum(int m);
    logic [127:0] s = '0;
    foreach (mq[m][i]) s += 128'(mq[m][i]);
    return s;
  endfunction

  task automatic model_check(int m, int accw, string tag, logic [127:0] acc, int cnt,
                             logic vld, logic rdy, logic ovf);
    logic [127:0] s    = model_sum(m);
    logic [127:0] mask = (128'(1) << accw) - 128'(1);
    chk({tag, "_acc"}, acc, s & mask);
    chk({tag, "_cnt"}, 128'(cnt), 128'(mq[m].size()));
    chk({tag, "_vld"}, 128'(vld), 128'(mhold[m]));
    chk({tag, "_rdy"}, 128'(rdy), 128'(!mhold[m]));
    chk({tag, "_ovf"}, 128'(ovf), 128'((s >> accw) != 0));
  endtask

  localparam logic [63:0] BIG = 64'hFFFF_FFFE_0000_0001;

  initial begin
    // Reset held two cycles with a valid product waiting upstream.
    rst = 1'b1; pv = 1'b1; pin = 64'd5; rr = 1'b0; clr = 1'b0;
    #1;
    chk("rst_rdy_comb", 128'(a_rdy), 128'(0));
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_rdy", 128'(a_rdy), 128'(0));
      chk("rst_acc", a_acc, 128'(0));
      chk("rst_cnt", 128'(a_cnt), 128'(0));
      chk("rst_vld", 128'(a_vld), 128'(0));
      chk("rst_ovf", 128'(a_ovf), 128'(0));
    end
    pv = 1'b0; rst = 1'b0;
    #1;
    chk("post_rst_rdy", 128'(a_rdy), 128'(1));
    chk("post_rst_cnt", 128'(a_cnt), 128'(0));

    // Vector table for BURST_LEN=4: basic burst, backpressure, clear cases.
    for (int k = 1; k <= 4; k++) add_row(1, 64'(k), 0, 1, 72'(k * (k + 1) / 2), k, k == 4);
    add_row(0, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) add_row(1, 64'(k), 0, 0, 72'(k * (k + 1) / 2), k, k == 4);
    for (int k = 0; k < 5; k++) add_row(1, 64'd7, 0, 0, 72'd10, 4, 1);
    add_row(1, 64'd7, 0, 1, 0, 0, 0);
    add_row(1, 64'd7, 0, 0, 72'd7, 1, 0);
    add_row(0, 0, 1, 0, 0, 0, 0);
    add_row(1, 64'd5, 0, 0, 72'd5, 1, 0);
    add_row(1, 64'd7, 0, 0, 72'd12, 2, 0);
    add_row(1, 64'd9, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) add_row(1, 64'd1, 0, 1, 72'(k), k, k == 4);
    add_row(0, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) add_row(1, 64'd2, 0, 0, 72'(2 * k), k, k == 4);
    add_row(1, 64'd3, 1, 0, 0, 0, 0);
    add_row(0, 0, 0, 0, 0, 0, 0);

    do_reset();
    foreach (vecs[i]) begin
      pv = vecs[i].v; pin = vecs[i].p; clr = vecs[i].c; rr = vecs[i].r;
      tick();
      chk("tbl_acc", a_acc, 128'(vecs[i].e_acc));
      chk("tbl_cnt", 128'(a_cnt), 128'(vecs[i].e_cnt));
      chk("tbl_vld", 128'(a_vld), 128'(vecs[i].e_vld));
      chk("tbl_rdy", 128'(a_rdy), 128'(!vecs[i].e_vld));
      chk("tbl_ovf", 128'(a_ovf), 128'(0));
    end

    // Reset while holding a result.
    do_reset();
    pv = 1'b1; pin = 64'd3;
    repeat (4) tick();
    pv = 1'b0;
    chk("hold_vld", 128'(a_vld), 128'(1));
    chk("hold_acc", a_acc, 128'(12));
    rst = 1'b1;
    tick();
    chk("rst_hold_vld", 128'(a_vld), 128'(0));
    chk("rst_hold_acc", a_acc, 128'(0));
    chk("rst_hold_cnt", 128'(a_cnt), 128'(0));
    rst = 1'b0;
    #1;
    chk("rst_hold_rdy", 128'(a_rdy), 128'(1));

    // Sixteen maximal products on the default configuration.
    do_reset();
    pv = 1'b1; pin = BIG;
    repeat (16) tick();
    pv = 1'b0;
    chk("max_acc", b_acc, 128'(72'hF_FFFF_FFE0_0000_0010));
    chk("max_ovf", 128'(b_ovf), 128'(0));
    chk("max_vld", 128'(b_vld), 128'(1));
    chk("max_cnt", 128'(b_cnt), 128'(16));
    chk("max_rdy", 128'(b_rdy), 128'(0));

    // Carry out of a 64-bit accumulator.
    do_reset();
    pv = 1'b1; pin = BIG;
    repeat (2) tick();
    pv = 1'b0;
    chk("ovf_acc", 128'(c_acc), 128'(64'hFFFF_FFFC_0000_0002));
    chk("ovf_flag", 128'(c_ovf), 128'(1));
    chk("ovf_vld", 128'(c_vld), 128'(1));
    rr = 1'b1;
    tick();
    rr = 1'b0;
    chk("ovf_clr_flag", 128'(c_ovf), 128'(0));
    chk("ovf_clr_vld", 128'(c_vld), 128'(0));
    chk("ovf_clr_acc", 128'(c_acc), 128'(0));

    // Randomized traffic on all four configurations against the model.
    do_reset();
    for (int m = 0; m < 4; m++) model_clear(m);
    for (int i = 0; i < 600; i++) begin
      pv  = ($urandom_range(0, 3) != 0);
      pin = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 15)))
                                        : {$urandom, $urandom};
      clr = ($urandom_range(0, 15) == 0);
      rr  = ($urandom_range(0, 1) == 1);
      tick();
      model_step(0, 4,  clr, pv, pin, rr);
      model_step(1, 16, clr, pv, pin, rr);
      model_step(2, 2,  clr, pv, pin, rr);
      model_step(3, 1,  clr, pv, pin, rr);
      model_check(0, 72, "rnd_a", 128'(a_acc), int'(a_cnt), a_vld, a_rdy, a_ovf);
      model_check(1, 72, "rnd_b", 128'(b_acc), int'(b_cnt), b_vld, b_rdy, b_ovf);
      model_check(2, 64, "rnd_c", 128'(c_acc), int'(c_cnt), c_vld, c_rdy, c_ovf);
      model_check(3, 72, "rnd_d", 128'(d_acc), int'(d_cnt), d_vld, d_rdy, d_ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
